// File: rtl/bus_mux_controller.sv
// Sequencing FSM for the 16-bit datapath: latches one instruction and
// drives bus-mux selects, register write enables and A/G loads per cycle.
module bus_mux_controller #(
  parameter int INSTR_W = 16,
  parameter bit B2B     = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  output logic               ir_load,
  output logic [2:0]         reg_sel,
  output logic               reg_r_sel,
  output logic               imm_sel,
  output logic [7:0]         reg_write,
  output logic               a_load,
  output logic               g_load,
  output logic [1:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [3:0] opcode;
  logic [2:0] rx, ry;
  logic [7:0] wr_rx;
  logic [1:0] alu_code;
  logic       is_mv, is_mvi, is_alu;
  logic       unused_ir;

  assign opcode = ir_q[INSTR_W-1 -: 4];
  assign rx     = ir_q[INSTR_W-5 -: 3];
  assign ry     = ir_q[INSTR_W-8 -: 3];
  assign wr_rx  = 8'd1 << rx;
  assign unused_ir = ^ir_q[INSTR_W-11:0];

  assign is_mv  = (opcode == OP_MV);
  assign is_mvi = (opcode == OP_MVI);
  assign is_alu = (opcode == OP_ADD) ||
                  (opcode == OP_SUB) ||
                  (opcode == OP_AND);

  assign alu_code = (opcode == OP_SUB) ? 2'b01 :
                    (opcode == OP_AND) ? 2'b10 :
                                         2'b00;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ir_load   = 1'b0;
    reg_sel   = 3'd0;
    reg_r_sel = 1'b0;
    imm_sel   = 1'b0;
    reg_write = 8'd0;
    a_load    = 1'b0;
    g_load    = 1'b0;
    alu_op    = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ir_load = run;
        if (run) begin
          ir_d    = instr;
          state_d = T1;
        end
      end
      T1: begin
        busy = 1'b1;
        unique case (1'b1)
          is_mv: begin
            reg_sel   = ry;
            reg_write = wr_rx;
            done      = 1'b1;
          end
          is_mvi: begin
            imm_sel   = 1'b1;
            reg_write = wr_rx;
            done      = 1'b1;
          end
          is_alu: begin
            reg_sel = rx;
            a_load  = 1'b1;
            state_d = T2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        busy    = 1'b1;
        reg_sel = ry;
        g_load  = 1'b1;
        alu_op  = alu_code;
        state_d = T3;
      end
      T3: begin
        busy      = 1'b1;
        reg_r_sel = 1'b1;
        reg_write = wr_rx;
        done      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // back-to-back issue: the done cycle doubles as the next accept cycle
    if (done) begin
      if (B2B && run) begin
        ir_load = 1'b1;
        ir_d    = instr;
        state_d = T1;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule
